seg7_scan: RTL and testbench

- Four-digit multiplexed seven-segment driver that consumes the 1 kHz square wave from the board's clock divider as a scan-rate signal.
- Runs entirely on the 100 MHz system clock. It detects rising edges of the scan input, rotates through the digits, decodes hex nibbles to segment patterns, and inserts a ghosting-blank gap before each new digit is lit.
- Sits between the datapath that produces display values and the board's anode/segment pins.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/hex_to_seg7.sv | 17 +
 rtl/seg7_scan.sv | 146 ++++++++++++++
 tb/tb_seg7_scan.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and tables for the multiplexed seven-segment scanner.
package seg7_pkg;

  // Digit index width; covers up to eight digits.
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}; entry 15 first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  // Next digit index, wrapping from the last digit back to digit 0.
  function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W-1:0] idx,
                                                input int n_digits);
    if (idx == IDX_W'(n_digits - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to seven-segment pattern, with selectable output polarity.
module hex_to_seg7
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  // Table lookup, inverted for common-anode wiring when requested.
  always_comb begin
    seg_o = SEG_LUT[nib_i];
    if (ACTIVE_LOW) seg_o = ~SEG_LUT[nib_i];
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit (parameterizable) multiplexed seven-segment scanner.
// Rotates one digit per scan tick, with an all-dark gap before each digit
// to suppress ghosting. Outputs are registered from next-state values so
// they move on the same edge as the FSM.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int BLANK_CYCLES   = 100,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  scan_i,
  input  logic                  en_i,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [N_DIGITS-1:0]   an_o
);

  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};

  state_e               state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 scan_q;
  logic                 tick;
  logic                 load;

  logic [4*N_DIGITS-1:0] data_q, data_nx;
  logic [N_DIGITS-1:0]   dp_q, dp_nx;
  logic [N_DIGITS-1:0]   blank_q, blank_nx;

  logic                  show_n;
  logic [N_DIGITS-1:0]   an_hot;
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic [6:0]            seg_dec;

  assign tick = scan_i & ~scan_q;

  // Next-state: enable drop wins over everything, including a same-cycle tick.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    load    = 1'b0;
    if (!en_i) begin
      state_n = S_OFF;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (tick) begin
            load    = 1'b1;
            idx_n   = '0;
            cnt_n   = CNT_LOAD;
            state_n = S_BLANK;
          end
        end
        S_BLANK: begin
          if (cnt_q == '0) state_n = S_SHOW;
          else             cnt_n   = cnt_q - CNT_W'(1);
        end
        S_SHOW: begin
          if (tick) begin
            idx_n   = idx_wrap(idx_q, N_DIGITS);
            // Shadows refresh only at the frame boundary for coherence.
            load    = (idx_q == LAST_IDX);
            cnt_n   = CNT_LOAD;
            state_n = S_BLANK;
          end
        end
        default: state_n = S_OFF;
      endcase
    end
  end

  // Shadow contents as they will be after this edge.
  always_comb begin
    data_nx  = load ? data_i  : data_q;
    dp_nx    = load ? dp_i    : dp_q;
    blank_nx = load ? blank_i : blank_q;
  end

  assign show_n = (state_n == S_SHOW);

  // Per-digit anode select, suppressed for blanked digits.
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_an
    assign an_hot[d] = show_n & (idx_n == IDX_W'(d)) & ~blank_nx[d];
  end

  // Mux the selected digit's nibble and dp into the single decoder.
  always_comb begin
    nib_sel = 4'h0;
    dp_sel  = 1'b0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (idx_n == IDX_W'(d)) begin
        nib_sel = data_nx[4*d +: 4];
        dp_sel  = dp_nx[d];
      end
    end
  end

  hex_to_seg7 #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .nib_i (nib_sel),
    .seg_o (seg_dec)
  );

  // State, shadows and registered pin drivers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      scan_q  <= 1'b0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      an_o    <= AN_OFF;
      seg_o   <= SEG_OFF;
      dp_o    <= SEG_ACTIVE_LOW;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      cnt_q   <= cnt_n;
      scan_q  <= scan_i;
      data_q  <= data_nx;
      dp_q    <= dp_nx;
      blank_q <= blank_nx;
      an_o    <= an_hot ^ AN_OFF;
      seg_o   <= show_n ? seg_dec : SEG_OFF;
      dp_o    <= (show_n & dp_sel) ^ SEG_ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: stimulus pushes expected digit displays,
// a monitor pops one whenever the outputs change to a new non-dark pattern.
module tb_seg7_scan;
  import seg7_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        scan_i = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blank_i = '0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  seg7_scan #(
    .N_DIGITS       (4),
    .BLANK_CYCLES   (100),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .scan_i    (scan_i),
    .en_i      (en_i),
    .data_i    (data_i),
    .dp_i      (dp_i),
    .blank_i   (blank_i),
    .seg_o     (seg_o),
    .dp_o      (dp_o),
    .an_o      (an_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         run;   // expected dark cycles before this digit, 0 = don't care
  } exp_t;

  localparam logic [11:0] INACT = {4'hF, 7'h7F, 1'b1};

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int run);
    exp_t e;
    e.an = an; e.seg = seg; e.dp = dp; e.run = run;
    exp_q.push_back(e);
  endtask

  // One-cycle scan pulse; returns just after the edge that detects it.
  task automatic tick();
    @(negedge clk_i);
    scan_i = 1'b1;
    @(posedge clk_i);
    #1 scan_i = 1'b0;
  endtask

  task automatic chk_dark(input string name);
    chk({name, "_an"},  32'(an_o),  32'h0F);
    chk({name, "_seg"}, 32'(seg_o), 32'h7F);
    chk({name, "_dp"},  32'(dp_o),  32'h1);
  endtask

  // Monitor: every change to a non-dark pattern is one displayed digit.
  logic [11:0] prev;
  int          run;
  always @(negedge clk_i) begin
    logic [11:0] cur;
    exp_t e;
    if (!mon_on) begin
      prev = INACT;
      run  = 0;
    end else begin
      cur = {an_o, seg_o, dp_o};
      if (cur == prev) begin
        run++;
      end else begin
        if (cur != INACT) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_digit: got an=%b seg=%h dp=%b expected none at %0t",
                     an_o, seg_o, dp_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("digit_an",  32'(an_o),  32'(e.an));
            chk("digit_seg", 32'(seg_o), 32'(e.seg));
            chk("digit_dp",  32'(dp_o),  32'(e.dp));
            if (e.run != 0) chk("blank_gap", 32'(run), 32'(e.run));
          end
        end
        prev = cur;
        run  = 1;
      end
    end
  end

  initial begin
    // Reset held with scan toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk_dark("reset");
      scan_i = ~scan_i;
    end
    reset_n_i = 1'b1;
    scan_i    = 1'b0;
    @(negedge clk_i);
    chk_dark("post_reset");
    mon_on = 1'b1;

    // Basic scan of 1234: digit 0 is the rightmost nibble.
    data_i = 16'h1234; dp_i = '0; blank_i = '0; en_i = 1'b1;
    repeat (10) @(posedge clk_i);
    push(4'b1110, ~7'h66, 1'b1, 0);   tick(); repeat (300) @(posedge clk_i);
    push(4'b1101, ~7'h4F, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1011, ~7'h5B, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b0111, ~7'h06, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);

    // Frame coherence: new data mid-frame waits for the wrap.
    push(4'b1110, ~7'h66, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1101, ~7'h4F, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    data_i = 16'hABCD;
    push(4'b1011, ~7'h5B, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b0111, ~7'h06, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1110, ~7'h5E, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);

    // Blank and dp take effect from the next frame.
    blank_i = 4'b0100; dp_i = 4'b0001;
    push(4'b1101, ~7'h39, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1011, ~7'h7C, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b0111, ~7'h77, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1110, ~7'h5E, 1'b0, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1101, ~7'h39, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1111, ~7'h7C, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b0111, ~7'h77, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1110, ~7'h5E, 1'b0, 100); tick(); repeat (300) @(posedge clk_i);
    push(4'b1101, ~7'h39, 1'b1, 100); tick(); repeat (300) @(posedge clk_i);

    // Enable drop coinciding with a tick while showing idx 1.
    @(negedge clk_i);
    en_i = 1'b0; scan_i = 1'b1;
    @(negedge clk_i);
    chk_dark("en_drop");
    chk("en_drop_state", 32'(dut.state_q), 32'(S_OFF));
    chk("en_drop_idx",   32'(dut.idx_q),   32'd1);
    scan_i = 1'b0;
    repeat (5) @(negedge clk_i);
    en_i = 1'b1;
    data_i = 16'h5678; dp_i = '0; blank_i = '0;
    repeat (20) @(negedge clk_i);
    chk_dark("en_idle");
    push(4'b1110, ~7'h7F, 1'b1, 0); tick(); repeat (300) @(posedge clk_i);

    // Reset at blank counter 50 after a tick.
    tick();
    repeat (49) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    chk_dark("mid_reset");
    chk("mid_reset_state", 32'(dut.state_q), 32'(S_OFF));
    reset_n_i = 1'b1;
    repeat (300) @(posedge clk_i);
    push(4'b1110, ~7'h7F, 1'b1, 0);
    tick();
    repeat (100) @(negedge clk_i);
    chk("restart_dark_an", 32'(an_o), 32'h0F);
    @(negedge clk_i);
    chk("restart_lit_an", 32'(an_o), 32'b1110);

    repeat (300) @(posedge clk_i);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
